// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier (spm_seq_mult).
package spm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } spm_state_e;

   // Number of bits needed to count 0..n-1; called with n = PW+1.
   function automatic int spm_clog2(input int n);
      int w;
      w = 32'sd0;
      for (int v = n - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
         w = w + 32'sd1;
      end
      return w;
   endfunction

endpackage

// File: rtl/spm_cs_stage.sv
// One carry-save stage of the serial-parallel multiplier chain: a full adder
// folding x_bit & y_bit into the sum handed down from the stage above.
module spm_cs_stage
   import spm_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic x_bit,
   input  logic y_bit,
   input  logic sum_in,
   output logic sum_q
);

   logic sum_r;
   logic carry_r;
   logic pp_s;
   logic fa_sum_s;
   logic fa_carry_s;

   assign pp_s       = x_bit & y_bit;
   assign fa_sum_s   = pp_s ^ sum_in ^ carry_r;
   assign fa_carry_s = (pp_s & sum_in) | (pp_s & carry_r) | (sum_in & carry_r);
   assign sum_q      = sum_r;

   // Sum/carry state: cleared when a new operation is accepted, advanced in RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r   <= 1'b0;
         carry_r <= 1'b0;
      end else if (clr) begin
         sum_r   <= 1'b0;
         carry_r <= 1'b0;
      end else if (en) begin
         sum_r   <= fa_sum_s;
         carry_r <= fa_carry_s;
      end
   end

endmodule

// File: rtl/spm_seq_mult.sv
// Serial-parallel multiplier: X loaded in parallel, Y streamed LSB-first through a
// carry-save chain, product collected into a result register. Define SPM_ACC_EN for the accumulator.
module spm_seq_mult
   import spm_pkg::*;
#(
   parameter int XW    = 8,
   parameter int YW    = 8,
   parameter int GUARD = 4,
   localparam int PW   = XW + YW,
`ifdef SPM_ACC_EN
   localparam int OW   = PW + GUARD
`else
   // GUARD only widens the output when the accumulator is built.
   localparam int OW   = PW + (GUARD - GUARD)
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] in_x,
   input  logic [YW-1:0] in_y,
   input  logic          in_signed,
`ifdef SPM_ACC_EN
   input  logic          in_acc,
`endif
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_p
);

   localparam int            CW       = spm_clog2(PW + 32'sd1);
   localparam logic [CW-1:0] CNT_LAST = CW'(PW - 32'sd1);

   spm_state_e    state_r;
   logic [CW-1:0] cnt_r;
   logic [PW-1:0] x_r;
   logic [PW-1:0] y_r;
   logic [PW-2:0] res_r;
   logic          in_ready_r;
   logic          out_valid_r;
   logic [OW-1:0] out_p_r;

   logic          accept_s;
   logic          run_s;
   logic          load_s;
   logic [PW-1:0] x_ext_s;
   logic [PW-1:0] y_ext_s;
   logic [PW-1:0] prod_s;
   logic [OW-1:0] result_s;
   logic [PW:0]   sum_chain_s;

   assign accept_s = (state_r == ST_IDLE) && in_valid && in_ready_r;
   assign run_s    = (state_r == ST_RUN);
   assign load_s   = (state_r == ST_DONE) && !out_valid_r;
   assign x_ext_s  = {{(PW-XW){in_signed & in_x[XW-1]}}, in_x};
   assign y_ext_s  = {{(PW-YW){in_signed & in_y[YW-1]}}, in_y};

   // The last product bit is still in stage 0 when DONE is entered; it joins here.
   assign prod_s   = {sum_chain_s[0], res_r};

   assign sum_chain_s[PW] = 1'b0;
   for (genvar i = 0; i < PW; i++) begin : g_stage
      spm_cs_stage u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr    (accept_s),
         .en     (run_s),
         .x_bit  (x_r[i]),
         .y_bit  (y_r[0]),
         .sum_in (sum_chain_s[i+1]),
         .sum_q  (sum_chain_s[i])
      );
   end

`ifdef SPM_ACC_EN
   logic          signed_r;
   logic          acc_en_r;
   logic [OW-1:0] acc_r;
   logic [OW-1:0] prod_ext_s;

   assign prod_ext_s = {{(OW-PW){signed_r & prod_s[PW-1]}}, prod_s};
   assign result_s   = (acc_en_r ? acc_r : {OW{1'b0}}) + prod_ext_s;

   // Accumulate mode latches with the operands; each finished product folds into acc_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         signed_r <= 1'b0;
         acc_en_r <= 1'b0;
         acc_r    <= {OW{1'b0}};
      end else if (accept_s) begin
         signed_r <= in_signed;
         acc_en_r <= in_acc;
      end else if (load_s) begin
         acc_r    <= result_s;
      end
   end
`else
   assign result_s = prod_s;
`endif

   // Control FSM, operand/stream registers and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CW{1'b0}};
         x_r         <= {PW{1'b0}};
         y_r         <= {PW{1'b0}};
         res_r       <= {(PW-1){1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_p_r     <= {OW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  state_r    <= ST_RUN;
                  cnt_r      <= {CW{1'b0}};
                  x_r        <= x_ext_s;
                  y_r        <= y_ext_s;
                  res_r      <= {(PW-1){1'b0}};
                  in_ready_r <= 1'b0;
               end
            end
            ST_RUN: begin
               // Upper y_r bits already hold the extension, so the stream needs no mode test.
               y_r   <= {y_r[PW-1], y_r[PW-1:1]};
               res_r <= {sum_chain_s[0], res_r[PW-2:1]};
               if (cnt_r == CNT_LAST) begin
                  state_r <= ST_DONE;
                  cnt_r   <= {CW{1'b0}};
               end else begin
                  cnt_r   <= cnt_r + CW'(1'b1);
               end
            end
            ST_DONE: begin
               if (load_s) begin
                  out_valid_r <= 1'b1;
                  out_p_r     <= result_s;
               end else if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
                  in_ready_r  <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= {CW{1'b0}};
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_p     = out_p_r;

endmodule

// File: tb/tb_spm_seq_mult.sv
// Self-checking bench for spm_seq_mult: 8x8 vector table plus hand-written corner sequences,
// and a randomized 5x11 instance against a reference product model (both builds of SPM_ACC_EN).
`timescale 1ns/1ps
module tb_spm_seq_mult;

   localparam int PW = 16;
`ifdef SPM_ACC_EN
   localparam int OW = PW + 4;
`else
   localparam int OW = PW;
`endif

   typedef struct {
      logic [7:0]  x;
      logic [7:0]  y;
      logic        sgn;
      logic [15:0] p;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
   logic [7:0]    a_in_x, a_in_y;
   logic [OW-1:0] a_out_p;
   logic          b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
   logic [4:0]    b_in_x;
   logic [10:0]   b_in_y;
   logic [OW-1:0] b_out_p;
`ifdef SPM_ACC_EN
   logic          a_in_acc, b_in_acc;
`endif

   int            pass_cnt = 0;
   int            chk_cnt  = 0;
   logic [OW-1:0] sb_q[$];
   vec_t          tbl[10];

   always #5 clk = ~clk;

   spm_seq_mult #(.XW(8), .YW(8), .GUARD(4)) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_x      (a_in_x),
      .in_y      (a_in_y),
      .in_signed (a_in_signed),
`ifdef SPM_ACC_EN
      .in_acc    (a_in_acc),
`endif
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_p     (a_out_p)
   );

   spm_seq_mult #(.XW(5), .YW(11), .GUARD(4)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_x      (b_in_x),
      .in_y      (b_in_y),
      .in_signed (b_in_signed),
`ifdef SPM_ACC_EN
      .in_acc    (b_in_acc),
`endif
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_p     (b_out_p)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Extend a 16-bit reference product to the output width.
   function automatic logic [OW-1:0] ext_exp(input logic [15:0] p, input logic sgn);
      longint v;
      v = sgn ? longint'($signed(p)) : longint'(p);
      return v[OW-1:0];
   endfunction

   // Wait (bounded) for out_valid on instance a; returns edges counted after the accept edge.
   task automatic wait_a(output int edges);
      edges = 0;
      do begin
         @(posedge clk); #1;
         edges++;
      end while (!a_out_valid && edges < 40);
   endtask

   task automatic run_a(input logic [7:0] x, input logic [7:0] y, input logic sgn,
                        input logic [OW-1:0] exp, input string tag);
      int            edges;
      logic [OW-1:0] want;
      @(negedge clk);
      check({tag, "_rdy"}, a_in_ready, 1);
      a_in_x = x; a_in_y = y; a_in_signed = sgn; a_in_valid = 1'b1;
      sb_q.push_back(exp);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      a_in_x = 8'($urandom); a_in_y = 8'($urandom); a_in_signed = ~sgn;
`ifdef SPM_ACC_EN
      a_in_acc = ~a_in_acc;
`endif
      check({tag, "_busy"}, a_in_ready, 0);
      wait_a(edges);
      check({tag, "_lat"}, edges, 17);
      want = sb_q.pop_front();
      check(tag, a_out_p, want);
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      check({tag, "_ack"}, a_out_valid, 0);
   endtask

   task automatic run_b(input logic [4:0] x, input logic [10:0] y, input logic sgn, input string tag);
      int            edges;
      longint        xv, yv;
      logic [63:0]   pr;
      logic [OW-1:0] want;
      xv = sgn ? longint'($signed(x)) : longint'(x);
      yv = sgn ? longint'($signed(y)) : longint'(y);
      pr = 64'(xv * yv);
      @(negedge clk);
      b_in_x = x; b_in_y = y; b_in_signed = sgn; b_in_valid = 1'b1;
`ifdef SPM_ACC_EN
      b_in_acc = 1'b0;
`endif
      sb_q.push_back(pr[OW-1:0]);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      b_in_x = 5'($urandom); b_in_y = 11'($urandom); b_in_signed = ~sgn;
`ifdef SPM_ACC_EN
      b_in_acc = 1'b1;
`endif
      edges = 0;
      do begin
         @(posedge clk); #1;
         edges++;
      end while (!b_out_valid && edges < 40);
      check({tag, "_lat"}, edges, 17);
      want = sb_q.pop_front();
      check(tag, b_out_p, want);
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
   endtask

   initial begin
      int            edges;
      logic [OW-1:0] want;

      tbl[0] = '{8'd50,  8'd206, 1'b0, 16'h283C};
      tbl[1] = '{8'd50,  8'hCE,  1'b1, 16'hF63C};
      tbl[2] = '{8'h80,  8'h80,  1'b1, 16'h4000};
      tbl[3] = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
      tbl[4] = '{8'h00,  8'hA7,  1'b0, 16'h0000};
      tbl[5] = '{8'h00,  8'hA7,  1'b1, 16'h0000};
      tbl[6] = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
      tbl[7] = '{8'h80,  8'h7F,  1'b1, 16'hC080};
      tbl[8] = '{8'h7F,  8'h7F,  1'b0, 16'h3F01};
      tbl[9] = '{8'd13,  8'd11,  1'b0, 16'h008F};

      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_x = 8'd0; a_in_y = 8'd0; a_in_signed = 1'b0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_x = 5'd0; b_in_y = 11'd0; b_in_signed = 1'b0; b_out_ready = 1'b0;
`ifdef SPM_ACC_EN
      a_in_acc = 1'b0; b_in_acc = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_in_ready", a_in_ready, 1);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_p", a_out_p, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
`ifdef SPM_ACC_EN
         a_in_acc = 1'b0;
`endif
         run_a(tbl[i].x, tbl[i].y, tbl[i].sgn, ext_exp(tbl[i].p, tbl[i].sgn), $sformatf("vec%0d", i));
      end

      // Stalled consumer with a pending request, then handshake coinciding with in_valid.
      @(negedge clk);
`ifdef SPM_ACC_EN
      a_in_acc = 1'b0;
`endif
      a_in_x = 8'd12; a_in_y = 8'd11; a_in_signed = 1'b0; a_in_valid = 1'b1;
      sb_q.push_back(ext_exp(16'd132, 1'b0));
      @(posedge clk); #1;
      a_in_x = 8'd9; a_in_y = 8'd9;
      wait_a(edges);
      check("stall_lat", edges, 17);
      want = sb_q.pop_front();
      for (int i = 0; i < 10; i++) begin
         check("stall_p", a_out_p, want);
         check("stall_in_ready", a_in_ready, 0);
         check("stall_out_valid", a_out_valid, 1);
         @(posedge clk); #1;
      end
      check("stall_p_end", a_out_p, want);
      a_out_ready = 1'b1;
      sb_q.push_back(ext_exp(16'd81, 1'b0));
      @(posedge clk); #1;
      a_out_ready = 1'b0;
      check("swap_idle_ready", a_in_ready, 1);
      check("swap_out_valid", a_out_valid, 0);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      check("swap_taken", a_in_ready, 0);
      wait_a(edges);
      check("swap_lat", edges, 17);
      want = sb_q.pop_front();
      check("swap_p", a_out_p, want);
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_out_ready = 1'b0;

      // Abort in RUN cycle 5.
      @(negedge clk);
      a_in_x = 8'd200; a_in_y = 8'd100; a_in_signed = 1'b0; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", a_out_valid, 0);
      check("abort_in_ready", a_in_ready, 1);
      check("abort_out_p", a_out_p, 0);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef SPM_ACC_EN
      a_in_acc = 1'b0;
`endif
      run_a(8'd3, 8'd7, 1'b0, ext_exp(16'd21, 1'b0), "post_abort");

`ifdef SPM_ACC_EN
      a_in_acc = 1'b0;
      run_a(8'd3, 8'd4, 1'b0, 20'd12, "acc_load");
      a_in_acc = 1'b1;
      run_a(8'd5, 8'd6, 1'b0, 20'd42, "acc_add");
      a_in_acc = 1'b1;
      run_a(8'hFF, 8'h01, 1'b1, 20'd41, "acc_neg");
`endif

      for (int i = 0; i < 40; i++) begin
         run_b(5'($urandom), 11'($urandom), i[0], $sformatf("rnd%0d", i));
      end
      run_b(5'h10, 11'h400, 1'b1, "rnd_minmin");
      run_b(5'h1F, 11'h7FF, 1'b0, "rnd_maxmax");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
